// File: rtl/cic_decimator.sv
// rtl/cic_decimator.sv - N-stage CIC decimator with rounding, saturation and overflow/underflow flags
module cic_decimator #(
    parameter int DATA_WIDTH = 16,
    parameter int N_STAGES   = 3,
    parameter int DECIM      = 4,
    parameter int GAIN_LOG2  = 0,
    parameter int INT_WIDTH  = DATA_WIDTH + N_STAGES * $clog2(DECIM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] cic_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] cic_out,
    output logic                  valid_out,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int LOG2_DECIM = $clog2(DECIM);
    localparam int S          = N_STAGES * LOG2_DECIM - GAIN_LOG2;

    localparam logic [LOG2_DECIM-1:0] LAST_PHASE = LOG2_DECIM'(DECIM - 1);
    localparam logic [INT_WIDTH:0]    ROUND_BIAS = (INT_WIDTH + 1)'(1) << (S - 1);
    localparam logic signed [INT_WIDTH:0] SAT_MAX =
        {{(INT_WIDTH - DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [INT_WIDTH:0] SAT_MIN =
        {{(INT_WIDTH - DATA_WIDTH + 2){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    logic [INT_WIDTH-1:0]  integ      [N_STAGES];
    logic [INT_WIDTH-1:0]  integ_next [N_STAGES];
    logic [INT_WIDTH-1:0]  dly        [N_STAGES];
    logic [INT_WIDTH-1:0]  comb_in    [N_STAGES];
    logic [INT_WIDTH-1:0]  comb_out   [N_STAGES];
    logic [LOG2_DECIM-1:0] phase;

    logic                  strobe;
    logic signed [INT_WIDTH:0] round_sum;
    logic signed [INT_WIDTH:0] t_val;

    assign strobe = valid_in && (phase == LAST_PHASE);

    // Integrators and combs are both chained within the cycle; wrap-around is modular by design.
    always_comb begin
        integ_next[0] = integ[0] + {{(INT_WIDTH - DATA_WIDTH){cic_in[DATA_WIDTH-1]}}, cic_in};
        for (int k = 1; k < N_STAGES; k++) begin
            integ_next[k] = integ[k] + integ_next[k-1];
        end
        comb_in[0]  = integ_next[N_STAGES-1];
        comb_out[0] = comb_in[0] - dly[0];
        for (int k = 1; k < N_STAGES; k++) begin
            comb_in[k]  = comb_out[k-1];
            comb_out[k] = comb_in[k] - dly[k];
        end
    end

    // Round half up, then arithmetic shift back towards the output scale.
    always_comb begin
        round_sum = {comb_out[N_STAGES-1][INT_WIDTH-1], comb_out[N_STAGES-1]} + ROUND_BIAS;
        t_val     = round_sum >>> S;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_STAGES; k++) begin
                integ[k] <= '0;
                dly[k]   <= '0;
            end
            phase     <= '0;
            cic_out   <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (valid_in) begin
                for (int k = 0; k < N_STAGES; k++) begin
                    integ[k] <= integ_next[k];
                end
                phase <= (phase == LAST_PHASE) ? '0 : phase + 1'b1;
            end
            if (strobe) begin
                for (int k = 0; k < N_STAGES; k++) begin
                    dly[k] <= comb_in[k];
                end
                valid_out <= 1'b1;
                if (t_val > SAT_MAX) begin
                    cic_out   <= {1'b0, {(DATA_WIDTH - 1){1'b1}}};
                    overflow  <= 1'b1;
                    underflow <= 1'b0;
                end else if (t_val < SAT_MIN) begin
                    cic_out   <= {1'b1, {(DATA_WIDTH - 1){1'b0}}};
                    overflow  <= 1'b0;
                    underflow <= 1'b1;
                end else begin
                    cic_out   <= t_val[DATA_WIDTH-1:0];
                    overflow  <= 1'b0;
                    underflow <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// tb/tb_cic_decimator.sv - self-checking bench for cic_decimator against a boxcar-convolution model
module tb_cic_decimator;

    localparam int NS = 3;
    localparam int D  = 4;
    localparam int L  = NS * (D - 1) + 1;
    localparam int S0 = NS * 2;
    localparam int S1 = NS * 2 - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [15:0] cic_in = 16'h0000;

    logic [15:0] out0, out1;
    logic        vo0, vo1, ov0, ov1, un0, un1;

    int n_checks = 0;
    int n_fail   = 0;

    longint      h    [L];
    longint      hist [L];
    int          phase_m;
    logic [15:0] e_out [2];
    logic        e_ov  [2];
    logic        e_un  [2];
    logic        e_vo;

    cic_decimator dut0 (
        .clk(clk), .rst(rst), .cic_in(cic_in), .valid_in(valid_in),
        .cic_out(out0), .valid_out(vo0), .overflow(ov0), .underflow(un0)
    );

    cic_decimator #(.GAIN_LOG2(1)) dut1 (
        .clk(clk), .rst(rst), .cic_in(cic_in), .valid_in(valid_in),
        .cic_out(out1), .valid_out(vo1), .overflow(ov1), .underflow(un1)
    );

    always #5 clk = ~clk;

    function automatic void norm(input longint y, input int s,
                                 output logic [15:0] o, output logic ov, output logic un);
        longint t;
        t  = (y + (longint'(1) << (s - 1))) >>> s;
        ov = 1'b0;
        un = 1'b0;
        if (t > 32767) begin
            o  = 16'h7FFF;
            ov = 1'b1;
        end else if (t < -32768) begin
            o  = 16'h8000;
            un = 1'b1;
        end else begin
            o = 16'(t);
        end
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int j = 0; j < L; j++) hist[j] = 0;
        phase_m = 0;
        for (int g = 0; g < 2; g++) begin
            e_out[g] = 16'h0000;
            e_ov[g]  = 1'b0;
            e_un[g]  = 1'b0;
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [15:0] d);
        longint y;
        rst      = r;
        valid_in = v;
        cic_in   = d;
        @(posedge clk);
        #1;
        e_vo = 1'b0;
        if (r) begin
            model_clear();
        end else if (v) begin
            for (int j = L - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = longint'($signed(d));
            if (phase_m == D - 1) begin
                y = 0;
                for (int j = 0; j < L; j++) y += h[j] * hist[j];
                norm(y, S0, e_out[0], e_ov[0], e_un[0]);
                norm(y, S1, e_out[1], e_ov[1], e_un[1]);
                e_vo = 1'b1;
            end
            phase_m = (phase_m + 1) % D;
        end
        chk("valid_out_g0", {15'b0, vo0}, {15'b0, e_vo});
        chk("valid_out_g1", {15'b0, vo1}, {15'b0, e_vo});
        chk("cic_out_g0",   out0, e_out[0]);
        chk("cic_out_g1",   out1, e_out[1]);
        chk("overflow_g0",  {15'b0, ov0}, {15'b0, e_ov[0]});
        chk("overflow_g1",  {15'b0, ov1}, {15'b0, e_ov[1]});
        chk("underflow_g0", {15'b0, un0}, {15'b0, e_un[0]});
        chk("underflow_g1", {15'b0, un1}, {15'b0, e_un[1]});
    endtask

    initial begin
        longint tmp [L];
        // Impulse response of N cascaded length-D boxcars.
        for (int j = 0; j < L; j++) h[j] = (j == 0) ? 1 : 0;
        for (int s = 0; s < NS; s++) begin
            for (int j = 0; j < L; j++) begin
                tmp[j] = 0;
                for (int k = 0; k < D; k++) if (j - k >= 0) tmp[j] += h[j-k];
            end
            for (int j = 0; j < L; j++) h[j] = tmp[j];
        end
        model_clear();

        // Reset state.
        step(1'b1, 1'b0, 16'h0000);
        step(1'b1, 1'b1, 16'h4000);

        // DC step, continuous.
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 16'h4000);

        // Gapped input, valid every third cycle.
        step(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 72; i++) step(1'b0, (i % 3) == 2, 16'h4000);

        // Saturation levels on the gain-2 instance.
        step(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 16'h6000);
        for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 16'hA000);
        for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 16'h2000);

        // Reset mid-frame; rst also overrides a coincident valid_in.
        step(1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'h4000);
        step(1'b0, 1'b1, 16'h4000);
        step(1'b1, 1'b1, 16'h4000);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 16'h4000);

        // Rounding: small DC and a single-LSB impulse.
        step(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 16'h0001);
        step(1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'h0001);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 16'h0000);

        // Integrator wrap soak: full-scale square wave, period 64 inputs.
        step(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 48000; i++) step(1'b0, 1'b1, ((i / 32) % 2) ? 16'h8001 : 16'h7FFF);

        // Random sparse data with occasional resets.
        step(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, 16'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cic_decimator.md
# cic_decimator

Multi-stage cascaded integrator-comb (CIC) decimator that sits directly downstream of `FIR_Filter` in the DFE filter array. It consumes the FIR's Q1.15 sample stream (`fir_out`/`valid_out`) and reduces the sample rate by `DECIM`. Its output is gain-normalised, rounded and saturated back to Q1.15, and carries the same valid/overflow/underflow signalling as the FIR.

## Interface
- `DATA_WIDTH`, 16: input/output sample width, signed Q1.15.
- `N_STAGES`, 3: number of integrator and comb stages (1..5).
- `DECIM`, 4: decimation ratio. Power of two, 2..16. `LOG2_DECIM` = log2(`DECIM`).
- `GAIN_LOG2`, 0: extra output gain of 2^`GAIN_LOG2`. Requires `S` = `N_STAGES`*`LOG2_DECIM` − `GAIN_LOG2` ≥ 1.
- `INT_WIDTH`, `DATA_WIDTH` + `N_STAGES`*`LOG2_DECIM`: integrator/comb register width (22 at defaults).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `cic_in` in `DATA_WIDTH`: signed input sample; connects to FIR `fir_out`.
- `valid_in` in 1: `cic_in` is valid this cycle; connects to FIR `valid_out`.
- `cic_out` out `DATA_WIDTH`: signed decimated output sample.
- `valid_out` out 1: one-cycle strobe marking a new `cic_out`.
- `overflow` out 1: current output was clipped to +max. Qualified by `valid_out`.
- `underflow` out 1: current output was clipped to −max. Qualified by `valid_out`.

## Operation
- Integrators update only on `valid_in`, chained within one cycle, all in two's-complement `INT_WIDTH` arithmetic:
  - `i1` = `i1` + sext(`cic_in`)
  - `ik` = `ik` + `i(k−1)`_next
- Integrator wrap-around is intentional, modular arithmetic and is not flagged.
- Phase counter (0..`DECIM`−1):
  - Increments on each `valid_in` and wraps to 0.
  - Cycles without `valid_in` do not advance it and do not change any state.
- Decimation strobe = `valid_in` && phase == `DECIM`−1.
- On the strobe, the comb chain takes `iN`_next and computes, chained combinationally:
  - `ck` = x(k) − `dk`, where x(1) = `iN`_next and x(k) = `c(k−1)`.
  - Each delay register `dk` is then loaded with x(k). Differential delay is 1.
- Normalisation, applied to the final comb result `cN` (`INT_WIDTH` bits):
  - Compute `t` = (`cN` + 2^(S−1)) >>> S, using `INT_WIDTH`+1 bits for the add (round half up).
  - If `t` > 2^(`DATA_WIDTH`−1)−1: output 0x7FFF, `overflow`=1.
  - If `t` < −2^(`DATA_WIDTH`−1): output 0x8000, `underflow`=1.
  - Otherwise output `t`[`DATA_WIDTH`−1:0].
- With `GAIN_LOG2` = 0 the normalised result cannot exceed range, so the flags stay 0.
- Reset, including mid-operation, clears every integrator, comb delay register and the phase counter, plus `cic_out`, `valid_out`, `overflow` and `underflow`. Any partial decimation frame is discarded.

## Timing
- Reset values: `cic_out`=0, `valid_out`=0, `overflow`=0, `underflow`=0.
- Latency: `valid_out` rises in the cycle after the clock edge that samples the `DECIM`-th valid input of a frame. `cic_out` and the flags are registered on that same edge.
- `valid_out` is high for exactly one cycle per `DECIM` accepted inputs. It is never asserted back-to-back unless `DECIM` valid inputs arrive in consecutive cycles, which can only happen when `DECIM`=1 and that value is disallowed.
- `cic_out`, `overflow` and `underflow` hold their values between strobes. `overflow` and `underflow` are cleared at the next strobe if that sample does not clip; they are meaningful only while `valid_out`=1.
- `valid_in` may be sparse or bursty; frame alignment is preserved across gaps.
- `rst` sampled high overrides `valid_in` in the same cycle.
- No backpressure: every strobe must be consumed.

## Test plan
- **DC step, defaults:** `cic_in`=0x4000 with `valid_in` every cycle after reset → outputs 0x1400, 0x3C00, 0x4000, 0x4000… (impulse-response partial sums 20/64, 60/64, 64/64). `valid_out` asserts on every 4th cycle, one cycle after each 4th input.
- **Gapped input:** same DC stimulus with `valid_in` high every 3rd cycle → identical output sequence. `valid_out` spacing becomes 12 cycles.
- **Saturation, `GAIN_LOG2`=1:**
  - DC 0x6000 → steady 0x7FFF with `overflow`=1 on each strobe.
  - DC 0xA000 → 0x8000 with `underflow`=1.
  - DC 0x2000 → 0x4000 with both flags 0.
- **Reset mid-frame:** feed 2 samples of 0x4000, assert `rst` for 1 cycle, then continuous 0x4000 → first output is 0x1400 and all outputs read 0 during reset. No strobe from the aborted frame.
- **Integrator wrap soak:** 48000 samples of a full-scale ±0x7FFF square wave with period 64 inputs → output matches the bit-accurate reference model for every sample. Steady-state magnitude stays bounded, showing modular wrap is harmless.
- **Rounding:** DC 0x0001 at defaults → steady-state output 0x0001. An impulse of 0x0001 followed by zeros → outputs 0x0000 for `t` below 0.5 LSB, matching the round-half-up rule.
